// File: rtl/case_op_arbiter_pkg.sv
// Shared definitions for the case_op_arbiter slice: unit op codes,
// sequencer states and the request-to-response latency.
package case_op_arbiter_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_PASS = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Cycles from the accept cycle to the first cycle with rsp_valid high.
  localparam int RSP_LATENCY = 3;

endpackage

// File: rtl/case_op_arbiter_rr_arbiter.sv
// Combinational round-robin grant: picks the first asserted request at or
// after ptr_i, wrapping modulo NREQ. The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic           found;
  int             pos;
  logic [IDW-1:0] pos_w;

  // Scan the requests in priority order starting from the pointer.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = |req_i;
    found   = 1'b0;
    pos     = 0;
    pos_w   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      pos_w = IDW'(pos);
      if (!found && req_i[pos_w]) begin
        found          = 1'b1;
        grant_o[pos_w] = 1'b1;
        idx_o          = pos_w;
      end
    end
  end

endmodule

// File: rtl/case_op_arbiter.sv
// Round-robin sequencer that shares one registered inc/pass/dec unit among
// NREQ requesters. One transaction is in flight at a time:
// IDLE (accept) -> ISSUE (drive unit) -> WAIT (capture) -> RESP (handshake).
module case_op_arbiter
  import case_op_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [1:0]            unit_select,
  output logic [WIDTH-1:0]      unit_number,
  input  logic [WIDTH-1:0]      unit_result
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gidx;
  logic             any_req;

  logic [1:0]       op_arr   [NREQ];
  logic [WIDTH-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i]   = req_op[2*i +: 2];
    assign data_arr[i] = req_data[WIDTH*i +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (any_req)
  );

  // Accept strobe only in IDLE; masked while reset is asserted so the port
  // shows its reset value even if requests are pending.
  assign req_ready = (state_q == ST_IDLE && !RST) ? grant : '0;

  // Next-state logic. sel_q/num_q double as the latched op and operand:
  // they are loaded at accept, so the unit sees them only during ISSUE,
  // and sel falls back to HOLD in every other state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    sel_d       = OP_HOLD;
    num_d       = num_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ISSUE;
          ptr_d   = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          id_d    = gidx;
          sel_d   = op_arr[gidx];
          num_d   = data_arr[gidx];
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = unit_result;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      sel_q       <= OP_HOLD;
      num_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      sel_q       <= sel_d;
      num_q       <= num_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign unit_select = sel_q;
  assign unit_number = num_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_case_op_arbiter.sv
// Bench for case_op_arbiter: models the shared inc/pass/dec unit, drives
// directed and random requests, and checks every transaction against a
// round-robin / arithmetic reference model.
module tb_case_op_arbiter;
  import case_op_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  RST;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic [1:0]            unit_select;
  logic [WIDTH-1:0]      unit_number;
  logic [WIDTH-1:0]      unit_result;

  int checks = 0;
  int fails  = 0;

  logic [1:0]       op_a  [NREQ];
  logic [WIDTH-1:0] dat_a [NREQ];
  logic [1:0]       ref_ptr;
  logic [WIDTH-1:0] ref_unit;

  case_op_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .unit_select (unit_select),
    .unit_number (unit_number),
    .unit_result (unit_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared unit: registered result, reset by the same RST.
  logic [WIDTH-1:0] unit_q;
  always_ff @(posedge clk or posedge RST) begin
    if (RST) unit_q <= '0;
    else begin
      case (unit_select)
        OP_INC:  unit_q <= unit_number + 8'd1;
        OP_PASS: unit_q <= unit_number;
        OP_DEC:  unit_q <= unit_number - 8'd1;
        default: unit_q <= unit_q;
      endcase
    end
  end
  assign unit_result = unit_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2]         = op_a[i];
      req_data[WIDTH*i +: WIDTH] = dat_a[i];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full transaction, starting at the beginning of an IDLE cycle.
  // Returns the granted requester; leaves the bench at the next IDLE cycle.
  task automatic txn(input logic [3:0] vld, input int stall, output int g);
    logic [1:0]       p;
    logic [1:0]       op;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_d;
    g = -1;
    drive();
    req_valid = vld;
    rsp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      p = ref_ptr + 2'(k);
      if (g < 0 && vld[p]) g = int'(p);
    end
    op = op_a[g];
    d  = dat_a[g];
    case (op)
      OP_INC:  exp_d = d + 8'd1;
      OP_PASS: exp_d = d;
      OP_DEC:  exp_d = d - 8'd1;
      default: exp_d = ref_unit;
    endcase
    // Accept cycle
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(4'b0001 << g));
    chk("accept_sel_hold", 32'(unit_select), 32'(OP_HOLD));
    next_cycle();
    // Issue cycle
    @(negedge clk);
    chk("issue_sel", 32'(unit_select), 32'(op));
    chk("issue_num", 32'(unit_number), 32'(d));
    chk("issue_ready", 32'(req_ready), 32'd0);
    chk("issue_rv", 32'(rsp_valid), 32'd0);
    for (int c = 2; c < RSP_LATENCY; c++) begin
      next_cycle();
      @(negedge clk);
      chk("wait_sel", 32'(unit_select), 32'(OP_HOLD));
      chk("wait_rv", 32'(rsp_valid), 32'd0);
      chk("wait_ready", 32'(req_ready), 32'd0);
    end
    next_cycle();
    // Response cycles, with optional backpressure
    for (int s = 0; s <= stall; s++) begin
      rsp_ready = (s == stall);
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_data", 32'(rsp_data), 32'(exp_d));
      chk("rsp_id", 32'(rsp_id), 32'(g));
      chk("rsp_ready_out", 32'(req_ready), 32'd0);
      chk("rsp_sel", 32'(unit_select), 32'(OP_HOLD));
      next_cycle();
    end
    rsp_ready = 1'b0;
    ref_ptr  = 2'(g + 1);
    ref_unit = exp_d;
  endtask

  initial begin
    int g;
    RST       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]  = OP_HOLD;
      dat_a[i] = '0;
    end
    ref_ptr  = '0;
    ref_unit = '0;

    // Reset state, with all requests pending
    req_valid = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_sel", 32'(unit_select), 32'(OP_HOLD));
    chk("rst_num", 32'(unit_number), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    RST = 1'b0;
    next_cycle();

    // Idle with no requests
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_sel", 32'(unit_select), 32'(OP_HOLD));
      chk("idle_rv", 32'(rsp_valid), 32'd0);
      next_cycle();
    end

    // Single increment
    op_a[0] = OP_INC; dat_a[0] = 8'h41;
    txn(4'b0001, 0, g);
    chk("inc_grant", 32'(g), 32'd0);

    // Wrap-around in both directions
    op_a[1] = OP_INC; dat_a[1] = 8'hFF;
    txn(4'b0010, 0, g);
    op_a[1] = OP_DEC; dat_a[1] = 8'h00;
    txn(4'b0010, 0, g);

    // HOLD read-back of the unit's last result
    op_a[0] = OP_PASS; dat_a[0] = 8'h5A;
    txn(4'b0001, 0, g);
    op_a[3] = OP_HOLD; dat_a[3] = 8'h00;
    txn(4'b1000, 0, g);

    // Backpressure with req2 waiting, then req2 accepted right after
    op_a[0] = OP_INC;  dat_a[0] = 8'h10;
    op_a[2] = OP_PASS; dat_a[2] = 8'h33;
    txn(4'b0101, 5, g);
    chk("bp_first", 32'(g), 32'd0);
    txn(4'b0101, 0, g);
    chk("bp_second", 32'(g), 32'd2);

    // Reset during WAIT: transaction discarded, pointer back to 0
    op_a[1] = OP_PASS; dat_a[1] = 8'h77;
    drive();
    req_valid = 4'b0010;
    next_cycle();
    next_cycle();
    req_valid = 4'hF;
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(unit_select), 32'(OP_HOLD));
    chk("mid_rst_num", 32'(unit_number), 32'd0);
    chk("mid_rst_rv", 32'(rsp_valid), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_data", 32'(rsp_data), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    next_cycle();
    RST = 1'b0;
    ref_ptr  = '0;
    ref_unit = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_rv", 32'(rsp_valid), 32'd0);
      next_cycle();
    end

    // Fairness: all four valid -> 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]  = OP_PASS;
      dat_a[i] = 8'(8'hA0 + i);
    end
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 0, g);
      chk("fair_all", 32'(g), 32'(i % 4));
    end
    // req0 and req2 persistently valid alternate
    for (int i = 0; i < 4; i++) begin
      txn(4'b0101, 0, g);
      chk("fair_02", 32'(g), (i % 2 == 0) ? 32'd2 : 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i]  = 2'($urandom_range(0, 3));
        dat_a[i] = 8'($urandom);
      end
      txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/case_op_arbiter.md
Name: case_op_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered inc/pass/dec unit among NREQ requesters.
- The unit's select codes are 00 = +1, 01 = pass, 10 = −1, 11 = hold. It has a 1-cycle registered result.
- This block accepts one request at a time, drives the unit's select and number inputs for exactly one cycle, captures the result, and returns it tagged with the requester ID.
- It sits between client logic and the shared unit instance.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: operand and result width. It must match the unit's width.
- IDW, $clog2(NREQ): width of the requester ID.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot accept strobe.
- req_op  in  2*NREQ  per-requester op code; requester i uses bits [2i+1:2i].
- req_data  in  WIDTH*NREQ  per-requester operand; requester i uses slice i.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept from the consumer.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  WIDTH  result returned to the requester.
- unit_select  out  2  drives the unit's select input.
- unit_number  out  WIDTH  drives the unit's operand input.
- unit_result  in  WIDTH  registered result from the unit.

Behaviour:
- Clock and reset: one clock, clk. RST is asynchronous and active-high.
- Reset values: state = IDLE; rr_ptr = 0; rsp_valid = 0; rsp_id = 0; rsp_data = 0; unit_select = 2'b11 (hold); unit_number = 0; req_ready = 0.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid index at or after rr_ptr, wrapping modulo NREQ.
  - req_ready[g] = 1 in this cycle only. It is combinational from state and req_valid.
  - Latch op_q, data_q and id_q = g.
  - Set rr_ptr = (g+1) mod NREQ, then go to ISSUE.
  - With no valid requests, stay in IDLE with req_ready = 0.
- ISSUE:
  - unit_select = op_q and unit_number = data_q, both registered outputs, for exactly one cycle. Go to WAIT.
- WAIT:
  - unit_select returns to 11 so the unit holds its result.
  - At the end of this cycle, rsp_data <= unit_result and rsp_id <= id_q. Go to RESP.
- RESP:
  - rsp_valid = 1. rsp_data and rsp_id stay stable until rsp_ready is high.
  - When rsp_valid and rsp_ready are both high, go to IDLE and drop rsp_valid on the next edge.
- Latency: accept in cycle T gives rsp_valid high in cycle T+3. Minimum spacing between accepts is 4 cycles when rsp_ready is tied high.
- Outside ISSUE, unit_select is always 11. This block never causes the unit to change its result spontaneously.
- Arithmetic:
  - The block performs none; it forwards the unit's modulo-2^WIDTH result.
  - 8'hFF +1 returns 8'h00. 8'h00 −1 returns 8'hFF.
- Op 11 (HOLD) is a legal request: a read-back of the unit's current result.
- Only one transaction is in flight. req_ready stays 0 in ISSUE, WAIT and RESP, even when req_valid is high.
- Requesters must hold valid, op and data stable until accepted. Dropping valid before accept is allowed; that requester is simply not granted.
- Simultaneous requests: round-robin order from rr_ptr. No requester waits more than NREQ−1 grants.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - An in-flight transaction is discarded and no response is produced.
  - The unit is reset independently by the same RST.

Decomposition:
- Shared package holds:
  - op codes OP_INC = 2'b00, OP_PASS = 2'b01, OP_DEC = 2'b10, OP_HOLD = 2'b11;
  - the FSM state enum (IDLE, ISSUE, WAIT, RESP);
  - RSP_LATENCY = 3.
- One sub-module: rr_arbiter.
  - Purely combinational grant.
  - Inputs: request vector and rr_ptr.
  - Outputs: one-hot grant, encoded index and any_req.
  - The pointer register stays in case_op_arbiter.

Test Plan:
- Single increment:
  - Stimulus: req0 op=00 data=8'h41 in cycle T; rsp_ready = 1.
  - Response: req_ready[0] high in T; unit_select = 00 and unit_number = 8'h41 in T+1; rsp_valid in T+3 with rsp_data = 8'h42, rsp_id = 0.
- Wrap-around:
  - Stimulus: req1 op=00 data=8'hFF, then req1 op=10 data=8'h00.
  - Response: rsp_data = 8'h00, then 8'hFF, with rsp_id = 1 both times.
- Fairness:
  - Stimulus: all four req_valid held high with distinct data, rsp_ready = 1.
  - Response: grants in order 0, 1, 2, 3, 0, each 4 cycles apart. req0 and req2 persistently valid alternate 0, 2, 0, 2.
- Backpressure:
  - Stimulus: hold rsp_ready = 0 for 5 cycles in RESP while req2 is valid.
  - Response: rsp_valid, rsp_data and rsp_id stay stable; req_ready = 0 throughout; unit_select = 11; req2 is accepted 1 cycle after the handshake.
- HOLD read-back:
  - Stimulus: req0 op=01 data=8'h5A, then req3 op=11 data=8'h00.
  - Response: second response has rsp_data = 8'h5A, rsp_id = 3.
- Reset mid-WAIT:
  - Stimulus: assert RST asynchronously during WAIT.
  - Response: all outputs at reset values immediately (unit_select = 11); no rsp_valid after release; the next request is granted starting from requester 0.
